// File: rtl/audio_pkg.sv
// Shared audio constants and FSM state encoding for the microphone level path
// and the downstream volume-bar renderer.
package audio_pkg;

    localparam int MIC_MIDPOINT = 2048;
    localparam int VOL_MAX      = 15;
    localparam int MIC_W        = 12;
    localparam int VOL_W        = 5;
    localparam int DEV_W        = MIC_W - 1;
    localparam int DEV_MAX      = (1 << DEV_W) - 1;

    typedef enum logic {
        ST_ACCUM  = 1'b0,
        ST_UPDATE = 1'b1
    } state_t;

    function automatic logic [DEV_W-1:0] dev_max(input logic [DEV_W-1:0] a,
                                                 input logic [DEV_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mic_abs_dev.sv
// Combinational absolute deviation of a microphone sample from the ADC
// midpoint, saturated to the 11-bit range.
module mic_abs_dev
    import audio_pkg::*;
#(
    parameter int MIDPOINT = MIC_MIDPOINT
) (
    input  logic [MIC_W-1:0] mic_in,
    output logic [DEV_W-1:0] dev
);

    logic signed [MIC_W:0] diff;
    logic        [MIC_W:0] mag;

    always_comb begin
        diff = $signed({1'b0, mic_in}) - $signed((MIC_W+1)'(MIDPOINT));
        mag  = diff[MIC_W] ? $unsigned(-diff) : $unsigned(diff);
        // Full-scale low code gives 2048, one more than fits in 11 bits
        if (mag > (MIC_W+1)'(DEV_MAX)) begin
            dev = DEV_W'(DEV_MAX);
        end else begin
            dev = mag[DEV_W-1:0];
        end
    end

endmodule

// File: rtl/mic_peak_level.sv
// Peak-level meter: max |mic - midpoint| over WINDOW accepted samples, mapped to 0..15.
// Optional build macro MIC_PEAK_DECAY_EN adds one-step-per-window release smoothing.
module mic_peak_level
    import audio_pkg::*;
#(
    parameter int WINDOW   = 4000,
    parameter int MIDPOINT = MIC_MIDPOINT,
    parameter int SHIFT    = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [MIC_W-1:0] mic_in,
    output logic [VOL_W-1:0] volume,
    output logic             volume_valid
);

    localparam int CNT_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DEV_W-1:0]   run_max_q, run_max_d;
    logic [DEV_W-1:0]   peak_q, peak_d;
    logic [VOL_W-1:0]   volume_q, volume_d;
    logic               volume_valid_q, volume_valid_d;

    logic [DEV_W-1:0]   dev;
    logic [DEV_W-1:0]   shifted;
    logic [VOL_W-1:0]   level;

    mic_abs_dev #(
        .MIDPOINT (MIDPOINT)
    ) u_abs_dev (
        .mic_in (mic_in),
        .dev    (dev)
    );

    always_comb begin
        shifted = peak_q >> SHIFT;
        if (shifted > DEV_W'(VOL_MAX)) begin
            level = VOL_W'(VOL_MAX);
        end else begin
            level = VOL_W'(shifted);
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        run_max_d      = run_max_q;
        peak_d         = peak_q;
        volume_d       = volume_q;
        volume_valid_d = 1'b0;

        case (state_q)
            ST_ACCUM: begin
                if (sample_valid) begin
                    if (cnt_q == CNT_W'(WINDOW - 1)) begin
                        // Terminal sample closes the window and counts toward its peak
                        peak_d    = dev_max(run_max_q, dev);
                        run_max_d = '0;
                        cnt_d     = '0;
                        state_d   = ST_UPDATE;
                    end else begin
                        run_max_d = dev_max(run_max_q, dev);
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_UPDATE: begin
`ifdef MIC_PEAK_DECAY_EN
                if (level >= volume_q) begin
                    volume_d = level;
                end else begin
                    volume_d = volume_q - VOL_W'(1);
                end
`else
                volume_d = level;
`endif
                volume_valid_d = 1'b1;
                state_d        = ST_ACCUM;
                // A sample here is sample 0 of the next window; run_max is already clear
                if (sample_valid) begin
                    run_max_d = dev;
                    cnt_d     = CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_ACCUM;
            cnt_q          <= '0;
            run_max_q      <= '0;
            peak_q         <= '0;
            volume_q       <= '0;
            volume_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            run_max_q      <= run_max_d;
            peak_q         <= peak_d;
            volume_q       <= volume_d;
            volume_valid_q <= volume_valid_d;
        end
    end

    assign volume       = volume_q;
    assign volume_valid = volume_valid_q;

endmodule

// File: tb/tb_mic_peak_level.sv
// Self-checking bench for mic_peak_level (WINDOW=4): window-level model checked
// every cycle, directed literal cases, then randomized traffic with resets.
module tb_mic_peak_level;

    localparam int WIN = 4;

    logic        clk;
    logic        reset;
    logic        sample_valid;
    logic [11:0] mic_in;
    logic [4:0]  volume;
    logic        volume_valid;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    mic_peak_level #(
        .WINDOW   (WIN),
        .MIDPOINT (2048),
        .SHIFT    (7)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .mic_in       (mic_in),
        .volume       (volume),
        .volume_valid (volume_valid)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // ---------------- behavioural model: list of window deviations ----------------
    int win_devs[$];
    bit pend = 0;
    int pend_level = 0;
    int exp_vol = 0;
    bit exp_valid = 0;

    function automatic int abs_dev(input int m);
        int d;
        d = m - 2048;
        if (d < 0) d = -d;
        if (d > 2047) d = 2047;
        return d;
    endfunction

    function automatic int window_level();
        int pk;
        int lv;
        pk = 0;
        foreach (win_devs[i]) if (win_devs[i] > pk) pk = win_devs[i];
        lv = pk / 128;
        if (lv > 15) lv = 15;
        return lv;
    endfunction

    function automatic int next_volume(input int lv, input int cur);
`ifdef MIC_PEAK_DECAY_EN
        return (lv >= cur) ? lv : cur - 1;
`else
        return lv;
`endif
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            win_devs.delete();
            pend      = 0;
            exp_vol   = 0;
            exp_valid = 0;
        end else begin
            exp_valid = pend;
            if (pend) exp_vol = next_volume(pend_level, exp_vol);
            pend = 0;
            if (sample_valid) begin
                win_devs.push_back(abs_dev(int'(mic_in)));
                if (win_devs.size() == WIN) begin
                    pend_level = window_level();
                    pend = 1;
                    win_devs.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (volume_valid !== exp_valid) begin
                errors++;
                $display("FAIL cycle_valid t=%0t got %0b expected %0b", $time, volume_valid, exp_valid);
            end
            checks++;
            if (volume !== 5'(exp_vol)) begin
                errors++;
                $display("FAIL cycle_volume t=%0t got %0d expected %0d", $time, volume, exp_vol);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s = %0d", name, act);
        end
    endtask

    task automatic feed(input int m, input bit v);
        mic_in       = 12'(m);
        sample_valid = v;
        @(negedge clk);
    endtask

    task automatic wait_pulse(input string name, input int exp_v, input int exp_wait);
        int  waited;
        bit  seen;
        seen = 0;
        waited = 0;
        sample_valid = 0;
        while (!seen && waited < 12) begin
            if (volume_valid) seen = 1;
            else begin
                @(negedge clk);
                waited++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got no pulse expected pulse within 12 cycles", name);
        end else begin
            chk({name, "_vol"}, int'(volume), exp_v);
            chk({name, "_lat"}, waited, exp_wait);
        end
    endtask

    task automatic window4(input string name, input int a, input int b, input int c,
                           input int d, input int exp_v);
        feed(a, 1); feed(b, 1); feed(c, 1); feed(d, 1);
        wait_pulse(name, exp_v, 1);
    endtask

    function automatic int pick(input int nodecay, input int decay);
`ifdef MIC_PEAK_DECAY_EN
        return decay;
`else
        return nodecay;
`endif
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int amp;
        int lo;
        int hi;
        reset        = 1;
        sample_valid = 0;
        mic_in       = 12'd2048;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset_volume", int'(volume), 0);
        chk("reset_valid", int'(volume_valid), 0);
        reset = 0;

        window4("silent", 2048, 2048, 2048, 2048, 0);
        window4("peak_4095", 2048, 2048, 4095, 2048, 15);
        window4("silent_after_peak", 2048, 2048, 2048, 2048, pick(0, 14));
        window4("dev_1048", 1000, 2048, 2048, 2048, pick(8, 13));
        window4("mic_zero_sat", 0, 2048, 2048, 2048, 15);

        // accepted only every 3rd cycle; 4095 on idle cycles must be ignored
        for (int i = 0; i < WIN; i++) begin
            feed(2048, 1);
            if (i != WIN - 1) begin
                feed(4095, 0);
                feed(4095, 0);
            end
        end
        wait_pulse("sparse_valid", pick(0, 14), 1);

        // reset mid-window discards the partial window
        feed(2048, 0);
        feed(4095, 1);
        feed(4095, 1);
        reset = 1;
        feed(2048, 0);
        reset = 0;
        chk("midreset_volume", int'(volume), 0);
        window4("post_reset", 2048, 2048, 2048, 2048, 0);

        // terminal sample 3072 in peak; sample in UPDATE cycle opens next window
        feed(2048, 1); feed(2048, 1); feed(2048, 1); feed(3072, 1);
        feed(4095, 1);
        chk("terminal_pulse", int'(volume_valid), 1);
        chk("terminal_vol", int'(volume), 8);
        feed(2048, 1); feed(2048, 1); feed(2048, 1);
        wait_pulse("update_sample", 15, 1);

        // randomized traffic with occasional resets
        amp = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 40 == 0) amp = $urandom_range(0, 2048);
            lo = (2048 - amp < 0) ? 0 : 2048 - amp;
            hi = (2048 + amp > 4095) ? 4095 : 2048 + amp;
            reset = ($urandom_range(0, 249) == 0);
            feed(int'($urandom_range(hi, lo)), ($urandom_range(0, 3) != 0));
        end
        reset = 0;
        sample_valid = 0;
        @(negedge clk);
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
